board_sysctl: RTL

BOARD_SYSCTL -- requirements
Module: board_sysctl

---
 rtl/board_sysctl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/board_sysctl.sv
// Board system controller: SEL2 and startup registers on a Wishbone-style bus,
// shadow-ROM window decode with a delayed ack, and a 50 Hz timer with a
// debounced on/off button and a pending-interrupt level.
module board_sysctl #(
   parameter logic [15:0] STARTUP   = 16'o160005,
   parameter logic [15:0] REG_BASE  = 16'o177714,
   parameter int unsigned ROM_WAIT  = 2,
   parameter int unsigned TIMER_DIV = 2000000,
   parameter int unsigned DEB_LEN   = 2
) (
   input  logic        clk_p,
   input  logic        rst_n,
   input  logic [15:0] wb_adr_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [1:0]  wb_sel_i,
   output logic        wb_ack_o,
   output logic        rom_stb_o,
   output logic        rom_ack_o,
   input  logic        timer_button,
   output logic        timer_status,
   output logic        timer_tick_o,
   output logic        timer_irq_o,
   input  logic        timer_iack_i
);

   localparam logic [15:0] START_ADR = REG_BASE + 16'd2;
   localparam logic [2:0]  ROM_LAST  = 3'(ROM_WAIT - 1);
   localparam logic [23:0] PRESC_MAX = 24'(TIMER_DIV - 1);

   typedef enum logic [1:0] {RegIdle, RegAck, RegHold} reg_st_e;
   typedef enum logic [1:0] {RomIdle, RomCount, RomAck} rom_st_e;

   reg_st_e r_reg_st, w_reg_st_d;
   rom_st_e r_rom_st, w_rom_st_d;

   logic [15:0]        r_sel2;
   logic [5:0]         r_start_bits;
   logic               r_armed;
   logic [2:0]         r_rom_cnt, w_rom_cnt_d;
   logic [23:0]        r_presc;
   logic               r_tick;
   logic               r_btn_meta, r_btn_sync;
   logic [DEB_LEN-1:0] r_deb;
   logic               r_latch;
   logic               r_status;
   logic               r_irq;

   logic        w_cycstb, w_hit_sel2, w_hit_start, w_hit;
   logic [15:0] w_startup;
   logic        w_rom_map;
   logic        w_unused_adr0;

   // Byte address bit 0 does not distinguish registers.
   assign w_unused_adr0 = wb_adr_i[0];

   assign w_cycstb    = wb_cyc_i & wb_stb_i;
   assign w_hit_sel2  = w_cycstb & (wb_adr_i[15:1] == REG_BASE[15:1]);
   assign w_hit_start = w_cycstb & (wb_adr_i[15:1] == START_ADR[15:1]);
   assign w_hit       = w_hit_sel2 | w_hit_start;
   assign w_startup   = {STARTUP[15:8], r_start_bits, STARTUP[1:0]};

   // Register handshake state; a strobe live across reset must drop before a new ack.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         r_reg_st <= RegIdle;
         r_armed  <= 1'b0;
      end else begin
         r_reg_st <= w_reg_st_d;
         if (!wb_stb_i) r_armed <= 1'b1;
      end
   end

   // Register handshake next state: one ack per strobe.
   always_comb begin
      w_reg_st_d = r_reg_st;
      unique case (r_reg_st)
         RegIdle: if (w_hit && r_armed) w_reg_st_d = RegAck;
         RegAck:  w_reg_st_d = RegHold;
         RegHold: if (!wb_stb_i) w_reg_st_d = RegIdle;
         default: w_reg_st_d = RegIdle;
      endcase
   end

   // Register handshake outputs: data only during the ack cycle.
   always_comb begin
      wb_ack_o = (r_reg_st == RegAck);
      wb_dat_o = 16'd0;
      if (wb_ack_o) begin
         if (w_hit_sel2)       wb_dat_o = r_sel2;
         else if (w_hit_start) wb_dat_o = w_startup;
      end
   end

   // Register writes land in the ack cycle, per enabled byte lane.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         r_sel2       <= 16'd0;
         r_start_bits <= STARTUP[7:2];
      end else if (r_reg_st == RegAck && wb_we_i) begin
         if (w_hit_sel2) begin
            if (wb_sel_i[0]) r_sel2[7:0]  <= wb_dat_i[7:0];
            if (wb_sel_i[1]) r_sel2[15:8] <= wb_dat_i[15:8];
         end
         if (w_hit_start && wb_sel_i[0]) r_start_bits <= wb_dat_i[7:2];
      end
   end

   // Shadow-ROM window decode; startup bits 2 and 3 enable the lower banks.
   always_comb begin
      w_rom_map = 1'b0;
      if (wb_adr_i[12:11] == 2'b00)
         w_rom_map = w_startup[2] | w_startup[3];
      if (wb_adr_i[12:11] == 2'b01 || wb_adr_i[12:11] == 2'b10)
         w_rom_map = w_startup[3];
      if (wb_adr_i[12:9] == 4'b1011)
         w_rom_map = 1'b1;
      rom_stb_o = w_cycstb & (wb_adr_i[15:13] == 3'b111) & w_rom_map;
   end

   // ROM ack state and wait counter.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         r_rom_st  <= RomIdle;
         r_rom_cnt <= 3'd0;
      end else begin
         r_rom_st  <= w_rom_st_d;
         r_rom_cnt <= w_rom_cnt_d;
      end
   end

   // ROM ack next state: count ROM_WAIT clocks, hold ack until the cycle ends.
   always_comb begin
      w_rom_st_d  = r_rom_st;
      w_rom_cnt_d = r_rom_cnt;
      unique case (r_rom_st)
         RomIdle: begin
            if (rom_stb_o) begin
               if (ROM_WAIT == 1) begin
                  w_rom_st_d = RomAck;
               end else begin
                  w_rom_st_d  = RomCount;
                  w_rom_cnt_d = 3'd1;
               end
            end
         end
         RomCount: begin
            if (!wb_cyc_i) begin
               w_rom_st_d  = RomIdle;
               w_rom_cnt_d = 3'd0;
            end else if (r_rom_cnt == ROM_LAST) begin
               w_rom_st_d = RomAck;
            end else begin
               w_rom_cnt_d = r_rom_cnt + 3'd1;
            end
         end
         RomAck: begin
            if (!wb_cyc_i) begin
               w_rom_st_d  = RomIdle;
               w_rom_cnt_d = 3'd0;
            end
         end
         default: begin
            w_rom_st_d  = RomIdle;
            w_rom_cnt_d = 3'd0;
         end
      endcase
   end

   // ROM ack output.
   always_comb begin
      rom_ack_o = (r_rom_st == RomAck);
   end

   // Free-running prescaler; tick is high for the clock following the wrap.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= 24'd0;
         r_tick  <= 1'b0;
      end else if (r_presc == PRESC_MAX) begin
         r_presc <= 24'd0;
         r_tick  <= 1'b1;
      end else begin
         r_presc <= r_presc + 24'd1;
         r_tick  <= 1'b0;
      end
   end

   // Button synchroniser and per-tick debounce shift register.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_meta <= 1'b0;
         r_btn_sync <= 1'b0;
         r_deb      <= '0;
      end else begin
         r_btn_meta <= timer_button;
         r_btn_sync <= r_btn_meta;
         if (r_tick) r_deb <= {r_deb[DEB_LEN-2:0], r_btn_sync};
      end
   end

   // Toggle enable once per accepted press; latch re-arms on a stable release.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         r_status <= 1'b1;
         r_latch  <= 1'b0;
      end else if ((&r_deb) && !r_latch) begin
         r_status <= ~r_status;
         r_latch  <= 1'b1;
      end else if (~|r_deb) begin
         r_latch <= 1'b0;
      end
   end

   // Pending interrupt: a tick wins over a simultaneous acknowledge.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n)            r_irq <= 1'b0;
      else if (!r_status)    r_irq <= 1'b0;
      else if (r_tick)       r_irq <= 1'b1;
      else if (timer_iack_i) r_irq <= 1'b0;
   end

   assign timer_status = r_status;
   assign timer_tick_o = r_tick;
   assign timer_irq_o  = r_irq;

endmodule
